// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared types and constants for the program loader
package prog_loader_pkg;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 8;

  localparam logic [DW-1:0] NOP_WORD = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    RUN,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - DEPTH x DW flop program store with clear-all and async read port
module prog_mem #(
  parameter int DEPTH = prog_loader_pkg::DEPTH,
  parameter int AW    = prog_loader_pkg::AW,
  parameter int DW    = prog_loader_pkg::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  import prog_loader_pkg::*;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  // Clear wins over a same-cycle write.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = clr ? NOP_WORD : mem_q[i];
    end
    if (we && !clr) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= NOP_WORD;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams a program into prog_mem, verifies its XOR checksum, gates cpu_run
module prog_loader #(
  parameter int DEPTH = prog_loader_pkg::DEPTH,
  parameter int AW    = prog_loader_pkg::AW,
  parameter int DW    = prog_loader_pkg::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  input  logic [AW-1:0] cpu_addr,
  output logic [DW-1:0] cpu_prog,
  output logic          cpu_run,
  output logic          busy,
  output logic          load_done,
  output logic          load_err,
  output logic [AW:0]   words_loaded
);
  import prog_loader_pkg::*;

  localparam logic [AW:0] LAST_ADDR = (AW+1)'(DEPTH - 1);

  loader_state_t state_q, state_d;
  // The write pointer doubles as the loaded-word count; both start at 0 and step together.
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [DW-1:0] xsum_q, xsum_d;
  logic          load_err_q, load_err_d;
  logic          load_done_q, load_done_d;
  logic          beat;
  logic          mem_clr;
  logic          mem_we;

  assign in_ready     = (state_q == LOAD) || (state_q == CHECK);
  assign busy         = in_ready;
  assign cpu_run      = (state_q == RUN);
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;
  assign words_loaded = wr_ptr_q;
  assign beat         = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    xsum_d      = xsum_q;
    load_err_d  = load_err_q;
    load_done_d = 1'b0;
    mem_clr     = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      IDLE, RUN, ERROR: begin
        if (load_start) begin
          state_d    = LOAD;
          mem_clr    = 1'b1;
          wr_ptr_d   = '0;
          xsum_d     = '0;
          load_err_d = 1'b0;
        end
      end
      LOAD: begin
        if (beat) begin
          mem_we   = 1'b1;
          xsum_d   = xsum_q ^ in_data;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (in_last || (wr_ptr_q == LAST_ADDR)) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (beat) begin
          if (in_data == xsum_q) begin
            state_d     = RUN;
            load_done_d = 1'b1;
          end else begin
            state_d    = ERROR;
            load_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      xsum_q      <= '0;
      load_err_q  <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      xsum_q      <= xsum_d;
      load_err_q  <= load_err_d;
      load_done_q <= load_done_d;
    end
  end

  prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mem_clr),
    .we    (mem_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (in_data),
    .raddr (cpu_addr),
    .rdata (cpu_prog)
  );

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed bench for prog_loader with a behavioural program-store model
module tb_prog_loader;

  localparam int P_IDLE = 0, P_LOAD = 1, P_CHECK = 2, P_RUN = 3, P_ERR = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       load_start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [3:0] cpu_addr = 4'h0;
  logic [7:0] cpu_prog;
  logic       cpu_run;
  logic       busy;
  logic       load_done;
  logic       load_err;
  logic [4:0] words_loaded;

  int checks = 0;
  int errors = 0;

  // Model: phase, stored bytes, count of bytes written, sticky error, done pulse.
  int         m_phase = P_IDLE;
  logic [7:0] m_mem [16] = '{default: 8'h00};
  int         m_n = 0;
  bit         m_err = 1'b0;
  bit         m_done = 1'b0;

  prog_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_start   (load_start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .cpu_addr     (cpu_addr),
    .cpu_prog     (cpu_prog),
    .cpu_run      (cpu_run),
    .busy         (busy),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    logic [7:0] x;
    bit accepting;
    if (!rst_n) begin
      m_phase = P_IDLE;
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      m_n = 0;
      m_err = 1'b0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      accepting = in_valid && (m_phase == P_LOAD || m_phase == P_CHECK);
      if (load_start && (m_phase == P_IDLE || m_phase == P_RUN || m_phase == P_ERR)) begin
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_n = 0;
        m_err = 1'b0;
        m_phase = P_LOAD;
      end else if (accepting && m_phase == P_LOAD) begin
        m_mem[m_n] = in_data;
        m_n++;
        if (in_last || m_n == 16) m_phase = P_CHECK;
      end else if (accepting && m_phase == P_CHECK) begin
        x = 8'h00;
        for (int i = 0; i < m_n; i++) x ^= m_mem[i];
        if (in_data == x) begin
          m_phase = P_RUN;
          m_done = 1'b1;
        end else begin
          m_phase = P_ERR;
          m_err = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cpu_prog", 32'(cpu_prog), 32'(m_mem[cpu_addr]));
    chk("cpu_run", 32'(cpu_run), 32'(m_phase == P_RUN));
    chk("in_ready", 32'(in_ready), 32'(m_phase == P_LOAD || m_phase == P_CHECK));
    chk("busy", 32'(busy), 32'(m_phase == P_LOAD || m_phase == P_CHECK));
    chk("load_done", 32'(load_done), 32'(m_done));
    chk("load_err", 32'(load_err), 32'(m_err));
    chk("words_loaded", 32'(words_loaded), 32'(m_n));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      in_valid = 1'b0;
      load_start = 1'b0;
      in_data = 8'($urandom);
      in_last = 1'($urandom);
      cpu_addr = 4'($urandom_range(0, 15));
      tick();
    end
  endtask

  task automatic start();
    load_start = 1'b1;
    in_valid = 1'b0;
    tick();
    load_start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    int n = 0;
    while (!in_ready && n < 20) begin
      idle(1);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    load_start = 1'b0;
    cpu_addr = 4'($urandom_range(0, 15));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string nm);
    cpu_addr = a;
    #1;
    chk(nm, 32'(cpu_prog), 32'(exp));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Reset contents and status.
    for (int a = 0; a < 16; a++) rd(4'(a), 8'h00, "rst_mem");
    chk("rst_cpu_run", 32'(cpu_run), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);

    // Three-byte program, good checksum 0x12^0x34^0x56 = 0x70.
    start();
    beat(8'h12, 1'b0);
    beat(8'h34, 1'b0);
    beat(8'h56, 1'b1);
    beat(8'h70, 1'b0);
    chk("ok_done_pulse", 32'(load_done), 32'd1);
    chk("ok_cpu_run", 32'(cpu_run), 32'd1);
    chk("model_phase_run", 32'(m_phase), 32'(P_RUN));
    idle(1);
    chk("ok_done_once", 32'(load_done), 32'd0);
    chk("ok_words", 32'(words_loaded), 32'd3);
    chk("model_n3", 32'(m_n), 32'd3);
    chk("model_mem2", 32'(m_mem[2]), 32'h56);
    rd(4'd0, 8'h12, "ok_mem0");
    rd(4'd1, 8'h34, "ok_mem1");
    rd(4'd2, 8'h56, "ok_mem2");
    rd(4'd3, 8'h00, "ok_mem3");

    // Same program, wrong checksum.
    start();
    beat(8'h12, 1'b0);
    beat(8'h34, 1'b0);
    beat(8'h56, 1'b1);
    beat(8'h71, 1'b0);
    chk("bad_err", 32'(load_err), 32'd1);
    chk("bad_cpu_run", 32'(cpu_run), 32'd0);
    chk("bad_in_ready", 32'(in_ready), 32'd0);
    idle(3);
    chk("bad_err_sticky", 32'(load_err), 32'd1);
    start();
    chk("restart_err_clr", 32'(load_err), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);

    // Full 16-byte load; 0^1^..^15 = 0, 17th beat is the checksum.
    for (int i = 0; i < 16; i++) beat(8'(i), 1'b0);
    chk("full_check_ready", 32'(in_ready), 32'd1);
    chk("full_words", 32'(words_loaded), 32'd16);
    beat(8'h00, 1'b1);
    chk("full_run", 32'(cpu_run), 32'd1);
    chk("full_done", 32'(load_done), 32'd1);
    chk("model_n16", 32'(m_n), 32'd16);
    rd(4'd15, 8'h0F, "full_mem15");
    rd(4'd7, 8'h07, "full_mem7");

    // Gapped stream with a stray load_start mid-load; checksum 0x17.
    start();
    beat(8'hA5, 1'b0);
    idle($urandom_range(1, 3));
    start();
    beat(8'h3C, 1'b0);
    idle($urandom_range(0, 3));
    beat(8'h0F, 1'b0);
    idle($urandom_range(0, 3));
    beat(8'h81, 1'b1);
    idle($urandom_range(0, 3));
    beat(8'h17, 1'b0);
    chk("gap_run", 32'(cpu_run), 32'd1);
    chk("gap_words", 32'(words_loaded), 32'd4);
    rd(4'd1, 8'h3C, "gap_mem1");
    rd(4'd3, 8'h81, "gap_mem3");
    rd(4'd4, 8'h00, "gap_mem4");

    // Reset in the middle of a reload from RUN.
    start();
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_run", 32'(cpu_run), 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd0);
    chk("rst_mid_words", 32'(words_loaded), 32'd0);
    for (int a = 0; a < 16; a++) rd(4'(a), 8'h00, "rst_mid_mem");
    tick();
    rst_n = 1'b1;
    idle(2);
    chk("post_rst_busy", 32'(busy), 32'd0);
    rd(4'd0, 8'h00, "post_rst_mem0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
